// File: rtl/rgb_frame_scheduler.sv
// SK6805 frame controller: round-robin-arbitrated colour buffer, periodic or on-demand streaming of
// pixels to the bit serializer, followed by the latch gap.
module rgb_frame_scheduler #(
   parameter int NUM_LEDS       = 2,
   parameter int IDX_W          = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
   parameter int REFRESH_CYCLES = 800000,
   parameter int LATCH_CYCLES   = 8000
) (
   input  logic             clk_100MHz,
   input  logic             Rst,
   input  logic             a_req_i,
   input  logic [IDX_W-1:0] a_idx_i,
   input  logic [23:0]      a_rgb_i,
   output logic             a_gnt_o,
   input  logic             b_req_i,
   input  logic [IDX_W-1:0] b_idx_i,
   input  logic [23:0]      b_rgb_i,
   output logic             b_gnt_o,
   output logic             wr_err_o,
   input  logic             frame_req_i,
   output logic             px_valid_o,
   output logic [23:0]      px_grb_o,
   input  logic             px_ready_i,
   output logic             led_rst_o,
   output logic             busy_o,
   output logic             frame_done_o,
   output logic [1:0]       dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SEND  = 2'd2,
      LATCH = 2'd3
   } state_t;

   localparam int DEPTH = 1 << IDX_W;
   localparam int TMR_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(REFRESH_CYCLES - 1);
   localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(LATCH_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_LEDS - 1);
   localparam logic [IDX_W:0]   NUM_LEDS_W = (IDX_W + 1)'(NUM_LEDS);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [LAT_W-1:0]   lat_q, lat_d;
   logic               pending_q, pending_d;
   logic [23:0]        px_grb_q, px_grb_d;
   logic               done_q, done_d;
   logic [TMR_W-1:0]   timer_q;
   logic               rr_q;
   logic               wr_err_q;
   logic [23:0]        colour_q [DEPTH];

   logic               a_gnt, b_gnt, wr_valid, wr_in_range, tick, trigger;
   logic [IDX_W-1:0]   wr_idx;
   logic [23:0]        wr_rgb, sel_rgb;

   // rr_q = 0 favours A on a dual request; a lone requester always wins.
   always_comb begin
      a_gnt = a_req_i;
      b_gnt = b_req_i;
      if (a_req_i && b_req_i) begin
         a_gnt = ~rr_q;
         b_gnt = rr_q;
      end
   end

   assign wr_valid    = a_gnt | b_gnt;
   assign wr_idx      = a_gnt ? a_idx_i : b_idx_i;
   assign wr_rgb      = a_gnt ? a_rgb_i : b_rgb_i;
   assign wr_in_range = ({1'b0, wr_idx} < NUM_LEDS_W);
   assign tick        = (timer_q == TMR_LAST);
   assign trigger     = tick | frame_req_i;
   assign sel_rgb     = colour_q[idx_q];

   always_ff @(posedge clk_100MHz) begin
      if (Rst) begin
         rr_q     <= 1'b0;
         wr_err_q <= 1'b0;
         timer_q  <= '0;
         for (int i = 0; i < DEPTH; i++) colour_q[i] <= '0;
      end else begin
         // Every dual-request cycle grants someone, so the pointer always flips on it.
         rr_q     <= rr_q ^ (a_req_i & b_req_i);
         wr_err_q <= wr_valid & ~wr_in_range;
         timer_q  <= tick ? '0 : timer_q + TMR_W'(1);
         if (wr_valid && wr_in_range) colour_q[wr_idx] <= wr_rgb;
      end
   end

   // Pixel handshake: px_valid_o is high for the whole SEND state with px_grb_o frozen; a pixel
   // transfers on the edge where px_valid_o & px_ready_i, and px_ready_i is ignored elsewhere.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      lat_d     = lat_q;
      pending_d = pending_q;
      px_grb_d  = px_grb_q;
      done_d    = 1'b0;
      if (state_q != IDLE && trigger) pending_d = 1'b1;
      case (state_q)
         IDLE: begin
            if (trigger || pending_q) begin
               state_d   = LOAD;
               idx_d     = '0;
               pending_d = 1'b0;
            end
         end
         LOAD: begin
            px_grb_d = {sel_rgb[15:8], sel_rgb[23:16], sel_rgb[7:0]};
            state_d  = SEND;
         end
         SEND: begin
            if (px_ready_i) begin
               if (idx_q == IDX_LAST) begin
                  state_d = LATCH;
                  lat_d   = '0;
               end else begin
                  state_d = LOAD;
                  idx_d   = idx_q + IDX_W'(1);
               end
            end
         end
         LATCH: begin
            if (lat_q == LAT_LAST) begin
               done_d    = 1'b1;
               pending_d = trigger;
               idx_d     = '0;
               state_d   = pending_q ? LOAD : IDLE;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_100MHz) begin
      if (Rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         lat_q     <= '0;
         pending_q <= 1'b0;
         px_grb_q  <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         lat_q     <= lat_d;
         pending_q <= pending_d;
         px_grb_q  <= px_grb_d;
         done_q    <= done_d;
      end
   end

   assign a_gnt_o      = a_gnt;
   assign b_gnt_o      = b_gnt;
   assign wr_err_o     = wr_err_q;
   assign px_valid_o   = (state_q == SEND);
   assign px_grb_o     = px_grb_q;
   assign led_rst_o    = (state_q == LATCH);
   assign busy_o       = (state_q != IDLE);
   assign frame_done_o = done_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_rgb_frame_scheduler.sv
// Bench for rgb_frame_scheduler: randomized writes and frames checked against a buffer-level model.
module tb_rgb_frame_scheduler;

   localparam int NUM_LEDS = 2;
   localparam int IDX_W    = 2;
   localparam int REFRESH  = 1000;
   localparam int LATCH    = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             a_req_i = 1'b0, b_req_i = 1'b0;
   logic [IDX_W-1:0] a_idx_i = '0, b_idx_i = '0;
   logic [23:0]      a_rgb_i = '0, b_rgb_i = '0;
   logic             frame_req_i = 1'b0, px_ready_i = 1'b0;
   logic             a_gnt_o, b_gnt_o, wr_err_o, px_valid_o, led_rst_o, busy_o, frame_done_o;
   logic [23:0]      px_grb_o;
   logic [1:0]       dbg_state_o;

   int checks = 0;
   int errors = 0;

   logic [23:0] model_buf [NUM_LEDS];
   bit          favour_a;
   logic [23:0] exp_q[$];
   logic [23:0] got_q[$];

   always #5 clk = ~clk;

   rgb_frame_scheduler #(
      .NUM_LEDS(NUM_LEDS), .IDX_W(IDX_W), .REFRESH_CYCLES(REFRESH), .LATCH_CYCLES(LATCH)
   ) dut (
      .clk_100MHz(clk), .Rst(rst),
      .a_req_i(a_req_i), .a_idx_i(a_idx_i), .a_rgb_i(a_rgb_i), .a_gnt_o(a_gnt_o),
      .b_req_i(b_req_i), .b_idx_i(b_idx_i), .b_rgb_i(b_rgb_i), .b_gnt_o(b_gnt_o),
      .wr_err_o(wr_err_o), .frame_req_i(frame_req_i),
      .px_valid_o(px_valid_o), .px_grb_o(px_grb_o), .px_ready_i(px_ready_i),
      .led_rst_o(led_rst_o), .busy_o(busy_o), .frame_done_o(frame_done_o),
      .dbg_state_o(dbg_state_o)
   );

   function automatic logic [23:0] wire_order(input logic [23:0] rgb);
      return {rgb[15:8], rgb[23:16], rgb[7:0]};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      a_req_i = 1'b0; b_req_i = 1'b0; frame_req_i = 1'b0; px_ready_i = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < NUM_LEDS; k++) model_buf[k] = '0;
      favour_a = 1'b1;
   endtask

   task automatic trigger_frame();
      frame_req_i = 1'b1;
      @(posedge clk); #1;
      frame_req_i = 1'b0;
   endtask

   task automatic load_expected();
      exp_q.delete();
      for (int k = 0; k < NUM_LEDS; k++) exp_q.push_back(wire_order(model_buf[k]));
   endtask

   // Drives one write cycle and returns the grants plus the wr_err_o seen in the following cycle.
   task automatic write_cycle(input logic ar, input logic [IDX_W-1:0] ai, input logic [23:0] ac,
                              input logic br, input logic [IDX_W-1:0] bi, input logic [23:0] bc,
                              output logic ga, output logic gb, output logic err);
      a_req_i = ar; a_idx_i = ai; a_rgb_i = ac;
      b_req_i = br; b_idx_i = bi; b_rgb_i = bc;
      @(negedge clk);
      ga = a_gnt_o; gb = b_gnt_o;
      @(posedge clk); #1;
      a_req_i = 1'b0; b_req_i = 1'b0;
      @(negedge clk);
      err = wr_err_o;
      @(posedge clk); #1;
   endtask

   // Observes cycles (cycle 0 = current) until frame_done_o, recording accepted pixels into got_q.
   task automatic collect_frame(input bit rand_ready, output int first_valid, output int lat_cycles,
                                output int done_cnt, output bit busy_at_done);
      got_q.delete();
      first_valid = -1; lat_cycles = 0; done_cnt = 0; busy_at_done = 1'b0;
      for (int cyc = 0; cyc < 400 && done_cnt == 0; cyc++) begin
         px_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         if (px_valid_o && first_valid < 0) first_valid = cyc;
         if (px_valid_o && px_ready_i) got_q.push_back(px_grb_o);
         if (led_rst_o) lat_cycles++;
         if (frame_done_o) begin done_cnt++; busy_at_done = busy_o; end
         @(posedge clk); #1;
      end
      px_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      int fv, lat, dn; bit bd; int extra;
      do_reset();
      checks++;
      if ({px_valid_o, px_grb_o, led_rst_o, busy_o, frame_done_o, wr_err_o, dbg_state_o} !== 31'd0) begin
         errors++; $display("FAIL reset_outputs: got valid=%b grb=%h rst=%b busy=%b done=%b err=%b st=%0d expected all 0",
                            px_valid_o, px_grb_o, led_rst_o, busy_o, frame_done_o, wr_err_o, dbg_state_o);
      end
      trigger_frame();
      collect_frame(1'b0, fv, lat, dn, bd);
      checks++; if (fv !== 1) begin errors++; $display("FAIL reset_latency: first valid cycle %0d expected 1", fv); end
      checks++; if (got_q.size() !== NUM_LEDS) begin errors++; $display("FAIL reset_pixel_count: got %0d expected %0d", got_q.size(), NUM_LEDS); end
      for (int k = 0; k < NUM_LEDS && k < got_q.size(); k++) begin
         checks++; if (got_q[k] !== 24'h000000) begin errors++; $display("FAIL reset_pixel%0d: got %h expected 000000", k, got_q[k]); end
      end
      checks++; if (lat !== LATCH) begin errors++; $display("FAIL reset_latch_len: got %0d expected %0d", lat, LATCH); end
      checks++; if (dn !== 1 || bd !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got count %0d busy %b expected 1 and 0", dn, bd); end
      extra = 0;
      repeat (20) begin @(negedge clk); if (frame_done_o || busy_o) extra++; @(posedge clk); #1; end
      checks++; if (extra !== 0) begin errors++; $display("FAIL reset_idle_after: got %0d active cycles expected 0", extra); end
   endtask

   task automatic test_colour_order();
      logic ga, gb, err; int fv, lat, dn; bit bd;
      do_reset();
      write_cycle(1'b1, 2'd0, 24'hFF8010, 1'b0, 2'd0, 24'h0, ga, gb, err);
      checks++; if ({ga, gb, err} !== 3'b100) begin errors++; $display("FAIL colour_a_grant: got gnt %b%b err %b expected 10 0", ga, gb, err); end
      write_cycle(1'b0, 2'd0, 24'h0, 1'b1, 2'd1, 24'h0000FF, ga, gb, err);
      checks++; if ({ga, gb, err} !== 3'b010) begin errors++; $display("FAIL colour_b_grant: got gnt %b%b err %b expected 01 0", ga, gb, err); end
      trigger_frame();
      collect_frame(1'b0, fv, lat, dn, bd);
      checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL colour_count: got %0d expected 2", got_q.size()); end
      else begin
         checks++; if (got_q[0] !== 24'h80FF10) begin errors++; $display("FAIL colour_px0: got %h expected 80ff10", got_q[0]); end
         checks++; if (got_q[1] !== 24'h0000FF) begin errors++; $display("FAIL colour_px1: got %h expected 0000ff", got_q[1]); end
      end
   endtask

   task automatic test_round_robin();
      int fv, lat, dn; bit bd; logic ea;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         a_req_i = 1'b1; a_idx_i = IDX_W'($urandom_range(0, 1)); a_rgb_i = 24'($urandom);
         b_req_i = 1'b1; b_idx_i = IDX_W'($urandom_range(0, 1)); b_rgb_i = 24'($urandom);
         ea = favour_a;
         @(negedge clk);
         checks++;
         if ({a_gnt_o, b_gnt_o} !== {ea, ~ea}) begin
            errors++; $display("FAIL rr_grant%0d: got %b%b expected %b%b", c, a_gnt_o, b_gnt_o, ea, ~ea);
         end
         if (ea) model_buf[a_idx_i] = a_rgb_i; else model_buf[b_idx_i] = b_rgb_i;
         favour_a = ~favour_a;
         @(posedge clk); #1;
      end
      a_req_i = 1'b0; b_req_i = 1'b0;
      load_expected();
      trigger_frame();
      collect_frame(1'b1, fv, lat, dn, bd);
      checks++; if (got_q.size() !== NUM_LEDS) begin errors++; $display("FAIL rr_count: got %0d expected %0d", got_q.size(), NUM_LEDS); end
      for (int k = 0; k < NUM_LEDS && k < got_q.size(); k++) begin
         checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rr_px%0d: got %h expected %h", k, got_q[k], exp_q[k]); end
      end
   endtask

   task automatic test_random_writes();
      int fv, lat, dn; bit bd; logic ea, eb, exp_err;
      logic [IDX_W-1:0] gi; logic [23:0] gc;
      do_reset();
      exp_err = 1'b0;
      for (int c = 0; c < 150; c++) begin
         a_req_i = 1'($urandom_range(0, 1)); a_idx_i = IDX_W'($urandom_range(0, 3)); a_rgb_i = 24'($urandom);
         b_req_i = 1'($urandom_range(0, 1)); b_idx_i = IDX_W'($urandom_range(0, 3)); b_rgb_i = 24'($urandom);
         if (a_req_i && b_req_i) begin ea = favour_a; eb = ~favour_a; favour_a = ~favour_a; end
         else begin ea = a_req_i; eb = b_req_i; end
         @(negedge clk);
         checks++; if (wr_err_o !== exp_err) begin errors++; $display("FAIL rand_err%0d: got %b expected %b", c, wr_err_o, exp_err); end
         checks++; if ({a_gnt_o, b_gnt_o} !== {ea, eb}) begin errors++; $display("FAIL rand_grant%0d: got %b%b expected %b%b", c, a_gnt_o, b_gnt_o, ea, eb); end
         gi = ea ? a_idx_i : b_idx_i; gc = ea ? a_rgb_i : b_rgb_i;
         exp_err = (ea || eb) && (int'(gi) >= NUM_LEDS);
         if ((ea || eb) && int'(gi) < NUM_LEDS) model_buf[gi] = gc;
         @(posedge clk); #1;
      end
      a_req_i = 1'b0; b_req_i = 1'b0;
      @(negedge clk);
      checks++; if (wr_err_o !== exp_err) begin errors++; $display("FAIL rand_err_last: got %b expected %b", wr_err_o, exp_err); end
      @(posedge clk); #1;
      load_expected();
      trigger_frame();
      collect_frame(1'b1, fv, lat, dn, bd);
      checks++; if (got_q.size() !== NUM_LEDS) begin errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), NUM_LEDS); end
      for (int k = 0; k < NUM_LEDS && k < got_q.size(); k++) begin
         checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand_px%0d: got %h expected %h", k, got_q[k], exp_q[k]); end
      end
   endtask

   task automatic test_ready_stall();
      logic ga, gb, err; int fv, lat, dn; bit bd; int bad;
      do_reset();
      for (int k = 0; k < NUM_LEDS; k++) begin
         model_buf[k] = 24'($urandom);
         write_cycle(1'b1, IDX_W'(k), model_buf[k], 1'b0, '0, '0, ga, gb, err);
      end
      trigger_frame();
      px_ready_i = 1'b0;
      @(posedge clk); #1;
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (px_valid_o !== 1'b1 || px_grb_o !== wire_order(model_buf[0])) bad++;
         @(posedge clk); #1;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad); end
      px_ready_i = 1'b1;
      @(posedge clk); #1;
      px_ready_i = 1'b0;
      @(negedge clk);
      checks++; if (px_valid_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL stall_advance_load: got valid %b busy %b expected 0 1", px_valid_o, busy_o); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (px_valid_o !== 1'b1 || px_grb_o !== wire_order(model_buf[1])) begin
         errors++; $display("FAIL stall_px1: got valid %b grb %h expected 1 %h", px_valid_o, px_grb_o, wire_order(model_buf[1]));
      end
      @(posedge clk); #1;
      collect_frame(1'b0, fv, lat, dn, bd);
      checks++; if (got_q.size() !== 1 || dn !== 1 || lat !== LATCH) begin
         errors++; $display("FAIL stall_finish: got px %0d done %0d latch %0d expected 1 1 %0d", got_q.size(), dn, lat, LATCH);
      end
   endtask

   task automatic test_coherency();
      logic ga, gb, err; int fv, lat, dn; bit bd; logic [23:0] c_old, c_new;
      do_reset();
      c_old = 24'($urandom); c_new = ~c_old;
      write_cycle(1'b1, 2'd0, c_old, 1'b0, '0, '0, ga, gb, err);
      model_buf[0] = c_old;
      trigger_frame();
      a_req_i = 1'b1; a_idx_i = 2'd0; a_rgb_i = c_new;
      @(posedge clk); #1;
      a_req_i = 1'b0;
      model_buf[0] = c_new;
      collect_frame(1'b0, fv, lat, dn, bd);
      checks++; if (got_q.size() < 1 || got_q[0] !== wire_order(c_old)) begin
         errors++; $display("FAIL coherency_old: got %h expected %h", (got_q.size() > 0) ? got_q[0] : 24'hx, wire_order(c_old));
      end
      trigger_frame();
      collect_frame(1'b0, fv, lat, dn, bd);
      checks++; if (got_q.size() < 1 || got_q[0] !== wire_order(c_new)) begin
         errors++; $display("FAIL coherency_new: got %h expected %h", (got_q.size() > 0) ? got_q[0] : 24'hx, wire_order(c_new));
      end
   endtask

   task automatic test_pending();
      logic ga, gb, err; int fv, lat, dn; bit bd; int stray;
      do_reset();
      for (int k = 0; k < NUM_LEDS; k++) begin
         model_buf[k] = 24'($urandom);
         write_cycle(1'b0, '0, '0, 1'b1, IDX_W'(k), model_buf[k], ga, gb, err);
      end
      load_expected();
      trigger_frame();
      px_ready_i = 1'b0;
      @(posedge clk); #1;
      repeat (3) begin
         frame_req_i = 1'b1; @(posedge clk); #1;
         frame_req_i = 1'b0; @(posedge clk); #1;
      end
      collect_frame(1'b1, fv, lat, dn, bd);
      checks++; if (dn !== 1 || bd !== 1'b1) begin errors++; $display("FAIL pend_first_done: got done %0d busy %b expected 1 1", dn, bd); end
      collect_frame(1'b0, fv, lat, dn, bd);
      checks++; if (fv !== 0) begin errors++; $display("FAIL pend_restart: first valid cycle %0d expected 0", fv); end
      checks++; if (got_q.size() !== NUM_LEDS || dn !== 1 || bd !== 1'b0) begin
         errors++; $display("FAIL pend_second: got px %0d done %0d busy %b expected %0d 1 0", got_q.size(), dn, bd, NUM_LEDS);
      end
      for (int k = 0; k < NUM_LEDS && k < got_q.size(); k++) begin
         checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL pend_px%0d: got %h expected %h", k, got_q[k], exp_q[k]); end
      end
      stray = 0;
      repeat (40) begin @(negedge clk); if (busy_o || px_valid_o) stray++; @(posedge clk); #1; end
      checks++; if (stray !== 0) begin errors++; $display("FAIL pend_single_extra: got %0d busy cycles expected 0", stray); end
   endtask

   task automatic test_err_and_abort();
      logic ga, gb, err; int fv, lat, dn; bit bd; int stray;
      do_reset();
      model_buf[0] = 24'($urandom); model_buf[1] = 24'($urandom);
      write_cycle(1'b1, 2'd0, model_buf[0], 1'b0, '0, '0, ga, gb, err);
      write_cycle(1'b0, '0, '0, 1'b1, 2'd1, model_buf[1], ga, gb, err);
      write_cycle(1'b1, 2'd2, 24'($urandom), 1'b0, '0, '0, ga, gb, err);
      checks++; if ({ga, err} !== 2'b11) begin errors++; $display("FAIL err_idx2: got gnt %b err %b expected 1 1", ga, err); end
      checks++; if (wr_err_o !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %b expected 0", wr_err_o); end
      write_cycle(1'b0, '0, '0, 1'b1, 2'd3, 24'($urandom), ga, gb, err);
      checks++; if ({gb, err} !== 2'b11) begin errors++; $display("FAIL err_idx3: got gnt %b err %b expected 1 1", gb, err); end
      load_expected();
      trigger_frame();
      collect_frame(1'b0, fv, lat, dn, bd);
      for (int k = 0; k < NUM_LEDS; k++) begin
         checks++; if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin errors++; $display("FAIL err_unchanged%0d: expected %h", k, exp_q[k]); end
      end
      trigger_frame();
      @(posedge clk); #1;
      checks++; if (px_valid_o !== 1'b1) begin errors++; $display("FAIL abort_in_send: got valid %b expected 1", px_valid_o); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if ({px_valid_o, px_grb_o, led_rst_o, busy_o, frame_done_o, wr_err_o} !== 29'd0) begin
         errors++; $display("FAIL abort_outputs: got valid %b busy %b grb %h done %b expected all 0", px_valid_o, busy_o, px_grb_o, frame_done_o);
      end
      stray = 0;
      repeat (30) begin @(negedge clk); if (frame_done_o || busy_o) stray++; @(posedge clk); #1; end
      checks++; if (stray !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", stray); end
   endtask

   task automatic test_auto_refresh();
      int fv, lat, dn; bit bd;
      do_reset();
      repeat (REFRESH - 1) @(posedge clk);
      #1;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL refresh_early: got busy %b expected 0", busy_o); end
      @(posedge clk); #1;
      checks++; if (busy_o !== 1'b1 || px_valid_o !== 1'b0) begin errors++; $display("FAIL refresh_load: got busy %b valid %b expected 1 0", busy_o, px_valid_o); end
      collect_frame(1'b0, fv, lat, dn, bd);
      checks++; if (fv !== 1 || got_q.size() !== NUM_LEDS || dn !== 1) begin
         errors++; $display("FAIL refresh_frame: got first %0d px %0d done %0d expected 1 %0d 1", fv, got_q.size(), dn, NUM_LEDS);
      end
   endtask

   initial begin
      test_reset();
      test_colour_order();
      test_round_robin();
      test_random_writes();
      test_ready_stall();
      test_coherency();
      test_pending();
      test_err_and_abort();
      test_auto_refresh();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
